// File: rtl/obi_bus_arbiter_if.sv
// Bus bundle between the core's instruction/data OBI masters, the arbiter and the SoC target.
// The slave modport is the arbiter's view; the master modport is the surrounding system.
interface obi_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      instr_req_i;
    logic                      instr_gnt_o;
    logic                      instr_rvalid_o;
    logic [ADDR_WIDTH-1:0]     instr_addr_i;
    logic [DATA_WIDTH-1:0]     instr_rdata_o;

    logic                      data_req_i;
    logic                      data_gnt_o;
    logic                      data_rvalid_o;
    logic [ADDR_WIDTH-1:0]     data_addr_i;
    logic                      data_we_i;
    logic [DATA_WIDTH/8-1:0]   data_be_i;
    logic [DATA_WIDTH-1:0]     data_wdata_i;
    logic [DATA_WIDTH-1:0]     data_rdata_o;

    logic                      soc_req_o;
    logic                      soc_gnt_i;
    logic                      soc_rvalid_i;
    logic [ADDR_WIDTH-1:0]     soc_addr_o;
    logic                      soc_we_o;
    logic [DATA_WIDTH/8-1:0]   soc_be_o;
    logic [DATA_WIDTH-1:0]     soc_wdata_o;
    logic [DATA_WIDTH-1:0]     soc_rdata_i;

    modport slave (
        input  instr_req_i, instr_addr_i,
               data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
               soc_gnt_i, soc_rvalid_i, soc_rdata_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
               data_gnt_o, data_rvalid_o, data_rdata_o,
               soc_req_o, soc_addr_o, soc_we_o, soc_be_o, soc_wdata_o
    );

    modport master (
        output instr_req_i, instr_addr_i,
               data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
               soc_gnt_i, soc_rvalid_i, soc_rdata_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
               data_gnt_o, data_rvalid_o, data_rdata_o,
               soc_req_o, soc_addr_o, soc_we_o, soc_be_o, soc_wdata_o
    );
endinterface

// File: rtl/obi_bus_arbiter.sv
// Two-master (instr/data) to one-target OBI arbiter, one outstanding transaction,
// with a per-transaction watchdog that forces an error response from a stalled target.
//
// state | meaning
// IDLE  | no transaction; arbitrate any pending request
// REQ   | request presented to target, waiting for soc_gnt_i
// RESP  | granted; address/control held from latch, waiting for soc_rvalid_i
module obi_bus_arbiter #(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter int          RR_MODE        = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    obi_bus_arbiter_if.slave bus,
    output logic             timeout_o
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int CW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]         CNT_INIT = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(32'hDEAD_BEEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    win_data_q, win_data_d;
    logic                    last_data_q, last_data_d;
    logic                    err_q, err_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    we_q;
    logic [BE_WIDTH-1:0]     be_q;
    logic [DATA_WIDTH-1:0]   wdata_q;

    logic                    expired;
    logic                    pick_data;
    logic                    latch_en;
    logic                    gnt;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    soc_req;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic                    win_we;
    logic [BE_WIDTH-1:0]     win_be;
    logic [DATA_WIDTH-1:0]   win_wdata;

    // The instruction port is read-only: it presents a full-word read.
    assign win_addr  = win_data_q ? bus.data_addr_i  : bus.instr_addr_i;
    assign win_we    = win_data_q & bus.data_we_i;
    assign win_be    = win_data_q ? bus.data_be_i    : {BE_WIDTH{1'b1}};
    assign win_wdata = win_data_q ? bus.data_wdata_i : '0;

    assign expired = (cnt_q == '0);

    always_comb begin
        pick_data = bus.data_req_i;
        if (RR_MODE != 0 && bus.data_req_i && bus.instr_req_i) begin
            pick_data = ~last_data_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        win_data_d  = win_data_q;
        last_data_d = last_data_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        latch_en    = 1'b0;
        gnt         = 1'b0;
        rvalid      = 1'b0;
        rdata       = '0;
        soc_req     = 1'b0;
        timeout_o   = 1'b0;

        // Watchdog saturates at terminal count so a late grant still sees expiry in RESP.
        if (state_q != IDLE && !expired) begin
            cnt_d = cnt_q - CW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (bus.data_req_i || bus.instr_req_i) begin
                    state_d    = REQ;
                    win_data_d = pick_data;
                    cnt_d      = CNT_INIT;
                    err_d      = 1'b0;
                end
            end
            REQ: begin
                soc_req = 1'b1;
                if (bus.soc_gnt_i || expired) begin
                    gnt      = 1'b1;
                    latch_en = 1'b1;
                    err_d    = ~bus.soc_gnt_i;
                    state_d  = RESP;
                end
            end
            RESP: begin
                // A real response beats a same-cycle expiry, unless the target never granted.
                if (bus.soc_rvalid_i && !err_q) begin
                    rvalid      = 1'b1;
                    rdata       = bus.soc_rdata_i;
                    state_d     = IDLE;
                    last_data_d = win_data_q;
                end else if (err_q || expired) begin
                    rvalid      = 1'b1;
                    rdata       = ERR_DATA;
                    timeout_o   = 1'b1;
                    state_d     = IDLE;
                    last_data_d = win_data_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            win_data_q  <= 1'b0;
            last_data_q <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            win_data_q  <= win_data_d;
            last_data_q <= last_data_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            if (latch_en) begin
                addr_q  <= win_addr;
                we_q    <= win_we;
                be_q    <= win_be;
                wdata_q <= win_wdata;
            end
        end
    end

    assign bus.soc_req_o   = soc_req;
    assign bus.soc_addr_o  = (state_q == REQ) ? win_addr  : addr_q;
    assign bus.soc_we_o    = (state_q == REQ) ? win_we    : we_q;
    assign bus.soc_be_o    = (state_q == REQ) ? win_be    : be_q;
    assign bus.soc_wdata_o = (state_q == REQ) ? win_wdata : wdata_q;

    assign bus.data_gnt_o     = gnt & win_data_q;
    assign bus.instr_gnt_o    = gnt & ~win_data_q;
    assign bus.data_rvalid_o  = rvalid & win_data_q;
    assign bus.instr_rvalid_o = rvalid & ~win_data_q;
    assign bus.data_rdata_o   = (rvalid & win_data_q)  ? rdata : '0;
    assign bus.instr_rdata_o  = (rvalid & ~win_data_q) ? rdata : '0;

endmodule

// File: tb/tb_obi_bus_arbiter.sv
// Bench for obi_bus_arbiter: drives a fixed-priority and a round-robin instance with the same
// directed stimulus and checks both against a transaction-level model every cycle.
module tb_obi_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    typedef struct packed {
        logic        ignt;
        logic        irv;
        logic [31:0] ird;
        logic        dgnt;
        logic        drv;
        logic [31:0] drd;
        logic        sreq;
        logic [31:0] saddr;
        logic        swe;
        logic [3:0]  sbe;
        logic [31:0] swd;
        logic        tmo;
    } out_t;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        instr_req  = 1'b0;
    logic        data_req   = 1'b0;
    logic        data_we    = 1'b0;
    logic        soc_gnt    = 1'b0;
    logic        soc_rvalid = 1'b0;
    logic [31:0] instr_addr = '0;
    logic [31:0] data_addr  = '0;
    logic [31:0] data_wdata = '0;
    logic [31:0] soc_rdata  = '0;
    logic [3:0]  data_be    = '0;

    out_t act [2];
    logic tmo [2];

    int n_vec  = 0;
    int n_fail = 0;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        obi_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
        assign bus.instr_req_i  = instr_req;
        assign bus.instr_addr_i = instr_addr;
        assign bus.data_req_i   = data_req;
        assign bus.data_addr_i  = data_addr;
        assign bus.data_we_i    = data_we;
        assign bus.data_be_i    = data_be;
        assign bus.data_wdata_i = data_wdata;
        assign bus.soc_gnt_i    = soc_gnt;
        assign bus.soc_rvalid_i = soc_rvalid;
        assign bus.soc_rdata_i  = soc_rdata;

        obi_bus_arbiter #(
            .ADDR_WIDTH    (AW),
            .DATA_WIDTH    (DW),
            .RR_MODE       (k),
            .TIMEOUT_CYCLES(TO)
        ) u_dut (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .bus      (bus),
            .timeout_o(tmo[k])
        );

        assign act[k] = {bus.instr_gnt_o, bus.instr_rvalid_o, bus.instr_rdata_o,
                         bus.data_gnt_o, bus.data_rvalid_o, bus.data_rdata_o,
                         bus.soc_req_o, bus.soc_addr_o, bus.soc_we_o, bus.soc_be_o,
                         bus.soc_wdata_o, tmo[k]};
    end

    // Transaction model: one open transaction per instance, tracked by its age in cycles.
    logic        m_open [2];
    logic        m_granted [2];
    logic        m_err [2];
    logic        m_data [2];
    logic        m_last_data [2];
    int          m_age [2];
    logic [31:0] m_addr [2];
    logic        m_we [2];
    logic [3:0]  m_be [2];
    logic [31:0] m_wd [2];

    always @(posedge clk_i or negedge rst_ni) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_ni) begin
                m_open[k]      <= 1'b0;
                m_granted[k]   <= 1'b0;
                m_err[k]       <= 1'b0;
                m_data[k]      <= 1'b0;
                m_last_data[k] <= 1'b0;
                m_age[k]       <= 0;
                m_addr[k]      <= '0;
                m_we[k]        <= 1'b0;
                m_be[k]        <= '0;
                m_wd[k]        <= '0;
            end else if (!m_open[k]) begin
                if (instr_req || data_req) begin
                    m_open[k]    <= 1'b1;
                    m_granted[k] <= 1'b0;
                    m_err[k]     <= 1'b0;
                    m_age[k]     <= 0;
                    if (instr_req && data_req)
                        m_data[k] <= (k == 1) ? !m_last_data[k] : 1'b1;
                    else
                        m_data[k] <= data_req;
                end
            end else if (!m_granted[k]) begin
                m_age[k] <= m_age[k] + 1;
                if (soc_gnt || m_age[k] >= TO - 1) begin
                    m_granted[k] <= 1'b1;
                    m_err[k]     <= !soc_gnt;
                    m_addr[k]    <= m_data[k] ? data_addr : instr_addr;
                    m_we[k]      <= m_data[k] && data_we;
                    m_be[k]      <= m_data[k] ? data_be : 4'hF;
                    m_wd[k]      <= m_data[k] ? data_wdata : 32'h0;
                end
            end else begin
                m_age[k] <= m_age[k] + 1;
                if (m_err[k] || soc_rvalid || m_age[k] >= TO - 1) begin
                    m_open[k]      <= 1'b0;
                    m_last_data[k] <= m_data[k];
                end
            end
        end
    end

    function automatic out_t model_out(input int k);
        out_t        e;
        logic        g;
        logic        v;
        logic [31:0] rd;
        e       = '0;
        g       = 1'b0;
        v       = 1'b0;
        rd      = '0;
        e.saddr = m_addr[k];
        e.swe   = m_we[k];
        e.sbe   = m_be[k];
        e.swd   = m_wd[k];
        if (m_open[k] && !m_granted[k]) begin
            e.sreq  = 1'b1;
            e.saddr = m_data[k] ? data_addr : instr_addr;
            e.swe   = m_data[k] && data_we;
            e.sbe   = m_data[k] ? data_be : 4'hF;
            e.swd   = m_data[k] ? data_wdata : 32'h0;
            g       = soc_gnt || (m_age[k] >= TO - 1);
        end else if (m_open[k]) begin
            if (m_err[k] || (!soc_rvalid && m_age[k] >= TO - 1)) begin
                v     = 1'b1;
                rd    = 32'hDEAD_BEEF;
                e.tmo = 1'b1;
            end else if (soc_rvalid) begin
                v  = 1'b1;
                rd = soc_rdata;
            end
        end
        e.dgnt = g && m_data[k];
        e.ignt = g && !m_data[k];
        e.drv  = v && m_data[k];
        e.irv  = v && !m_data[k];
        e.drd  = (v && m_data[k])  ? rd : 32'h0;
        e.ird  = (v && !m_data[k]) ? rd : 32'h0;
        return e;
    endfunction

    always @(negedge clk_i) begin
        for (int k = 0; k < 2; k++) begin
            out_t e;
            e = model_out(k);
            n_vec++;
            if (act[k] !== e) begin
                n_fail++;
                $display("FAIL cycle_model dut%0d t=%0t: got %h expected %h", k, $time, act[k], e);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s t=%0t: got %h expected %h", name, $time, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic probe();
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_soc_req", 32'(act[0].sreq), 0);
        chk("rst_soc_addr", act[0].saddr, 0);
        chk("rst_timeout", 32'(act[1].tmo), 0);

        // Single data read
        rst_ni = 1'b1; soc_gnt = 1'b1; data_req = 1'b1; data_addr = 32'h1000_0000;
        step(); probe();
        chk("s1_data_gnt", 32'(act[0].dgnt), 1);
        chk("s1_instr_gnt", 32'(act[0].ignt), 0);
        chk("s1_soc_addr", act[0].saddr, 32'h1000_0000);
        step();
        data_req = 1'b0; soc_rvalid = 1'b1; soc_rdata = 32'h1234_5678; probe();
        chk("s1_data_rvalid", 32'(act[0].drv), 1);
        chk("s1_data_rdata", act[0].drd, 32'h1234_5678);
        chk("s1_instr_rvalid", 32'(act[0].irv), 0);
        step();
        soc_rvalid = 1'b0;

        // Both masters requesting: fixed priority vs round robin from reset
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1; instr_req = 1'b1; data_req = 1'b1; soc_rvalid = 1'b1;
        instr_addr = 32'h0000_0100; data_addr = 32'h2000_0000; soc_rdata = 32'hA5A5_0001;
        for (int t = 0; t < 3; t++) begin
            step(); probe();
            chk("s2_fixed_data_gnt", 32'(act[0].dgnt), 1);
            chk("s2_rr_data_gnt", 32'(act[1].dgnt), (t == 1) ? 0 : 1);
            chk("s2_rr_instr_gnt", 32'(act[1].ignt), (t == 1) ? 1 : 0);
            step(); step();
        end
        data_req = 1'b0;
        step(); probe();
        chk("s2_fixed_instr_gnt", 32'(act[0].ignt), 1);
        chk("s2_instr_soc_be", 32'(act[0].sbe), 32'hF);
        step(); probe();
        chk("s2_instr_rdata", act[0].ird, 32'hA5A5_0001);
        step();
        instr_req = 1'b0; soc_rvalid = 1'b0;

        // Address stays latched while the master changes it during RESP
        data_req = 1'b1; data_addr = 32'h0F00_0000;
        step(); probe();
        chk("s3_addr_req", act[0].saddr, 32'h0F00_0000);
        step();
        data_req = 1'b0; data_addr = 32'h0A00_0004; probe();
        chk("s3_addr_resp1", act[0].saddr, 32'h0F00_0000);
        step();
        soc_rvalid = 1'b1; soc_rdata = 32'h55AA_55AA; probe();
        chk("s3_addr_resp2", act[0].saddr, 32'h0F00_0000);
        chk("s3_data_rvalid", 32'(act[0].drv), 1);
        step();
        soc_rvalid = 1'b0;

        // Write with a one-cycle-late target grant
        data_req = 1'b1; data_we = 1'b1; data_be = 4'b0011; data_wdata = 32'h0000_CAFE;
        data_addr = 32'h3000_0000; soc_gnt = 1'b0;
        step(); probe();
        chk("s4_gnt_wait", 32'(act[0].dgnt), 0);
        chk("s4_we_req", 32'(act[0].swe), 1);
        soc_gnt = 1'b1; probe();
        chk("s4_gnt", 32'(act[0].dgnt), 1);
        step();
        data_req = 1'b0; data_we = 1'b0; data_be = 4'hF; data_wdata = 32'h0; probe();
        chk("s4_we_hold", 32'(act[0].swe), 1);
        chk("s4_be_hold", 32'(act[0].sbe), 32'h3);
        chk("s4_wdata_hold", act[0].swd, 32'h0000_CAFE);
        step();
        soc_rvalid = 1'b1; probe();
        chk("s4_rvalid", 32'(act[0].drv), 1);
        step();
        soc_rvalid = 1'b0;

        // Target never grants
        data_req = 1'b1; data_addr = 32'h4000_0000; soc_gnt = 1'b0;
        for (int a = 0; a < TO; a++) begin
            step(); probe();
            chk("s5_timeout_gnt", 32'(act[0].dgnt), (a == TO - 1) ? 1 : 0);
        end
        step();
        data_req = 1'b0; probe();
        chk("s5_err_rvalid", 32'(act[0].drv), 1);
        chk("s5_err_rdata", act[0].drd, 32'hDEAD_BEEF);
        chk("s5_timeout", 32'(act[0].tmo), 1);
        chk("s5_timeout_rr", 32'(act[1].tmo), 1);
        step(); probe();
        chk("s5_idle_req", 32'(act[0].sreq), 0);
        chk("s5_idle_tmo", 32'(act[0].tmo), 0);

        // Granted, response never arrives: expiry in RESP
        data_req = 1'b1; data_addr = 32'h5000_0000; soc_gnt = 1'b1;
        step();
        data_req = 1'b0;
        for (int a = 1; a < TO - 1; a++) begin
            step(); probe();
            chk("s6_no_rvalid", 32'(act[0].drv), 0);
        end
        step(); probe();
        chk("s6_resp_timeout", 32'(act[0].tmo), 1);
        chk("s6_resp_rdata", act[0].drd, 32'hDEAD_BEEF);
        step();

        // Response arriving in the expiry cycle wins
        data_req = 1'b1;
        step();
        data_req = 1'b0;
        for (int a = 1; a < TO - 1; a++) step();
        step();
        soc_rvalid = 1'b1; soc_rdata = 32'h600D_600D; probe();
        chk("s7_real_rdata", act[0].drd, 32'h600D_600D);
        chk("s7_no_timeout", 32'(act[0].tmo), 0);
        step();
        soc_rvalid = 1'b0;

        // Reset in RESP, then a late target response
        data_req = 1'b1; data_addr = 32'h7000_0000;
        step();
        step();
        data_req = 1'b0; probe();
        chk("s8_addr_before_rst", act[0].saddr, 32'h7000_0000);
        rst_ni = 1'b0;
        #1;
        chk("s8_rst_addr", act[0].saddr, 0);
        chk("s8_rst_req", 32'(act[0].sreq), 0);
        chk("s8_rst_rvalid", 32'(act[0].drv), 0);
        step();
        rst_ni = 1'b1; soc_rvalid = 1'b1; soc_rdata = 32'h1111_1111; probe();
        chk("s8_late_rvalid", 32'(act[0].drv), 0);
        chk("s8_late_rvalid_rr", 32'(act[1].drv), 0);
        step();
        soc_rvalid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/obi_bus_arbiter.md
Name: obi_bus_arbiter

Overview:
- Two-master to one-target arbiter for the core's OBI-style instruction and data ports, feeding the SoC peripheral bus (RAM, SPI flash, UART, LED).
- Allows one outstanding transaction at a time.
- Latches address and control at grant, so the target sees a stable address through the response phase.
- A per-transaction watchdog prevents a stalled target (e.g. uninitialised SPI flash) from hanging the core.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width of all ports
RR_MODE, 0, 0 = fixed priority (data over instr), 1 = round-robin
TIMEOUT_CYCLES, 1024, cycles in REQ+RESP before forced error response; must be >= 2

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
instr_req_i  in  1  instruction request
instr_gnt_o  out  1  instruction grant
instr_rvalid_o  out  1  instruction response valid
instr_addr_i  in  ADDR_WIDTH  instruction address
instr_rdata_o  out  DATA_WIDTH  instruction read data
data_req_i  in  1  data request
data_gnt_o  out  1  data grant
data_rvalid_o  out  1  data response valid
data_addr_i  in  ADDR_WIDTH  data address
data_we_i  in  1  data write enable
data_be_i  in  DATA_WIDTH/8  data byte enables
data_wdata_i  in  DATA_WIDTH  data write data
data_rdata_o  out  DATA_WIDTH  data read data
soc_req_o  out  1  target request
soc_gnt_i  in  1  target grant
soc_rvalid_i  in  1  target response valid
soc_addr_o  out  ADDR_WIDTH  target address
soc_we_o  out  1  target write enable
soc_be_o  out  DATA_WIDTH/8  target byte enables
soc_wdata_o  out  DATA_WIDTH  target write data
soc_rdata_i  in  DATA_WIDTH  target read data
timeout_o  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset values: all gnt/rvalid/req outputs 0, timeout_o 0. soc_addr_o, soc_we_o, soc_be_o, soc_wdata_o and latched registers 0. State IDLE. RR pointer favours data.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - If any req is high, register the winner and go to REQ next cycle. Minimum 1 cycle arbitration latency.
  - soc_req_o = 0.
- Winner selection:
  - RR_MODE=0: data wins if data_req_i, else instr.
  - RR_MODE=1: if both request, pick the master not served last. Pointer updates on transaction completion, including timeout.
- REQ:
  - soc_req_o = 1. soc_addr/we/be/wdata driven combinationally from the winning master's inputs.
  - Instruction master drives we=0, be=all ones, wdata=0.
  - On soc_gnt_i: the winner's gnt_o is asserted in the same cycle (combinational passthrough). Address and control are latched; go to RESP.
  - Loser gnt_o stays 0.
  - Winner dropping req before gnt is a master protocol violation; behaviour undefined, no check required.
- RESP:
  - soc_req_o = 0. soc_* outputs driven from latched registers; stable until rvalid.
  - On soc_rvalid_i: the winner's rvalid_o and rdata_o mirror the target in the same cycle; go to IDLE.
  - Non-winner rdata_o = 0.
- soc_rvalid_i in IDLE or REQ is ignored. The target must return rvalid at least 1 cycle after gnt.
- Watchdog:
  - Counter clears on entering REQ and increments every cycle in REQ/RESP.
  - When the count reaches TIMEOUT_CYCLES-1 without completion:
    - If in REQ: pulse winner gnt_o.
    - Next cycle: pulse winner rvalid_o with rdata_o = 32'hDEAD_BEEF.
    - Assert timeout_o together with that rvalid_o.
    - Deassert soc_req_o; return to IDLE.
  - If in RESP at expiry, the error rvalid is issued that cycle.
  - A late target rvalid after timeout is dropped.
- Simultaneous expiry and soc_rvalid_i: the real response wins; no timeout_o.
- Reset mid-transaction: immediate return to IDLE, all outputs to reset values; in-flight response discarded.
- Back-to-back: after rvalid in cycle N, the next grant can reach the target no earlier than N+2 (IDLE, then REQ).

Test Plan:
- Single data read, target gnt same cycle as req, rvalid 1 cycle later, rdata 0x12345678 -> data_gnt_o at cycle 1 after req, data_rvalid_o with 0x12345678 at cycle 2; instr_* stay 0.
- Both requests held, RR_MODE=0, 3 transactions -> data served 3 times; instr only after data_req_i drops. With RR_MODE=1 -> order data, instr, data.
- Target gnt, then winner changes data_addr_i to 0x0A000004 during RESP -> soc_addr_o holds latched 0x0F000000 until rvalid.
- Target never grants, TIMEOUT_CYCLES=8 -> gnt pulse at cycle 7 in REQ; next cycle rvalid with 0xDEADBEEF and timeout_o=1; FSM in IDLE.
- rst_ni asserted in RESP -> all outputs 0 asynchronously; a late soc_rvalid_i after reset release produces no master rvalid.
- Write: data_we_i=1, be=4'b0011, wdata 0xCAFE -> soc_we_o=1, soc_be_o=0011, soc_wdata_o=0xCAFE held through RESP.
